// File: rtl/exec_status_if.sv
// Core-side execution events that feed the status reporter.
// The core (or the bench) drives the master side and the reporter samples the slave side.
interface exec_status_if;
    logic instr_valid;
    logic illegal_insn;
    logic exit_valid;

    modport master (
        output instr_valid,
        output illegal_insn,
        output exit_valid
    );

    modport slave (
        input instr_valid,
        input illegal_insn,
        input exit_valid
    );
endinterface

// File: rtl/exec_status_led_ctrl.sv
// Turns core execution events into sticky terminal states and drives the board LEDs.
// LED/done outputs trail the state register by one edge so every output comes straight from a flop.
module exec_status_led_ctrl #(
    parameter int unsigned ILLEGAL_MASK_CYCLES = 6,
    parameter int unsigned TIMEOUT_CYCLES      = 20000000,
    parameter int unsigned HB_DIV_LOG2         = 22,
    parameter int unsigned CNT_W               = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    exec_status_if.slave      ev_if,
    output logic [7:0]        led_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  cycle_cnt_o
);

    localparam logic [1:0] ST_RUN          = 2'd0;
    localparam logic [1:0] ST_EXIT_VALID   = 2'd1;
    localparam logic [1:0] ST_EXIT_ILLEGAL = 2'd2;
    localparam logic [1:0] ST_EXIT_TIMEOUT = 2'd3;

    localparam int unsigned MASK_W = (ILLEGAL_MASK_CYCLES > 0) ? $clog2(ILLEGAL_MASK_CYCLES + 1) : 1;
    localparam logic [MASK_W-1:0]      MASK_LIMIT   = MASK_W'(ILLEGAL_MASK_CYCLES);
    localparam logic [MASK_W-1:0]      MASK_ONE     = MASK_W'(1);
    localparam logic [HB_DIV_LOG2-1:0] HB_ONE       = HB_DIV_LOG2'(1);
    localparam logic [CNT_W-1:0]       CNT_ONE      = CNT_W'(1);
    localparam bit                     TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0]       TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

    logic [1:0]             state_q, state_d;
    logic [MASK_W-1:0]      mask_cnt_q, mask_cnt_d;
    logic [HB_DIV_LOG2-1:0] hb_q, hb_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             led_q, led_d;
    logic                   done_q, done_d;

    logic mask_active_s;
    logic illegal_evt_s;
    logic timeout_evt_s;
    logic in_run_s;

    assign in_run_s      = (state_q == ST_RUN);
    assign mask_active_s = (mask_cnt_q < MASK_LIMIT);
    assign illegal_evt_s = ev_if.instr_valid & ev_if.illegal_insn & ~mask_active_s;
    assign timeout_evt_s = TIMEOUT_EN & (cnt_q == TIMEOUT_LAST);

    // Next state: EXIT states are sticky; simultaneous events resolve illegal > valid > timeout.
    always_comb begin
        state_d = state_q;
        if (in_run_s) begin
            if (illegal_evt_s) begin
                state_d = ST_EXIT_ILLEGAL;
            end else if (ev_if.exit_valid) begin
                state_d = ST_EXIT_VALID;
            end else if (timeout_evt_s) begin
                state_d = ST_EXIT_TIMEOUT;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Counters: mask window saturates, cycle count saturates and freezes on exit, heartbeat clears on exit.
    always_comb begin
        mask_cnt_d = mask_cnt_q;
        hb_d       = hb_q;
        cnt_d      = cnt_q;
        if (mask_active_s) begin
            mask_cnt_d = mask_cnt_q + MASK_ONE;
        end else begin
            mask_cnt_d = mask_cnt_q;
        end
        if (in_run_s) begin
            hb_d = hb_q + HB_ONE;
            if (&cnt_q) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            hb_d  = '0;
            cnt_d = cnt_q;
        end
    end

    // LED image of the current state; heartbeat bit taken from the incremented count.
    always_comb begin
        led_d  = 8'h00;
        done_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                led_d[0] = hb_d[HB_DIV_LOG2-1];
                led_d[1] = 1'b1;
            end
            ST_EXIT_TIMEOUT: begin
                led_d[4] = 1'b1;
                done_d   = 1'b1;
            end
            ST_EXIT_ILLEGAL: begin
                led_d[5] = 1'b1;
                done_d   = 1'b1;
            end
            ST_EXIT_VALID: begin
                led_d[6] = 1'b1;
                done_d   = 1'b1;
            end
            default: begin
                led_d  = 8'h00;
                done_d = 1'b0;
            end
        endcase
        led_d[2] = mask_active_s;
        led_d[3] = 1'b0;
        led_d[7] = done_d;
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_RUN;
            mask_cnt_q <= '0;
            hb_q       <= '0;
            cnt_q      <= '0;
            led_q      <= 8'h02;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_cnt_q <= mask_cnt_d;
            hb_q       <= hb_d;
            cnt_q      <= cnt_d;
            led_q      <= led_d;
            done_q     <= done_d;
        end
    end

    assign led_o       = led_q;
    assign done_o      = done_q;
    assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_exec_status_led_ctrl.sv
// Directed bench for exec_status_led_ctrl: two instances (no-timeout fast heartbeat, 50-cycle timeout)
// with expectations queued as stimulus is applied and popped at each observation point.
module tb_exec_status_led_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  led_a, led_b;
    logic        done_a, done_b;
    logic [31:0] cnt_a, cnt_b;

    exec_status_if a_if ();
    exec_status_if b_if ();

    exec_status_led_ctrl #(
        .ILLEGAL_MASK_CYCLES(6),
        .TIMEOUT_CYCLES(0),
        .HB_DIV_LOG2(4),
        .CNT_W(32)
    ) dut_a (
        .clk_i(clk),
        .rst_ni(rst_n),
        .ev_if(a_if),
        .led_o(led_a),
        .done_o(done_a),
        .cycle_cnt_o(cnt_a)
    );

    exec_status_led_ctrl #(
        .ILLEGAL_MASK_CYCLES(6),
        .TIMEOUT_CYCLES(50),
        .HB_DIV_LOG2(22),
        .CNT_W(32)
    ) dut_b (
        .clk_i(clk),
        .rst_ni(rst_n),
        .ev_if(b_if),
        .led_o(led_b),
        .done_o(done_b),
        .cycle_cnt_o(cnt_b)
    );

    typedef struct {
        string       tag;
        bit          sel_b;
        logic [7:0]  mask;
        logic [7:0]  led;
        logic        done;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input bit sel_b, input logic [7:0] mask,
                        input logic [7:0] led, input logic done, input logic [31:0] cnt);
        exp_t e;
        e.tag = tag; e.sel_b = sel_b; e.mask = mask; e.led = led; e.done = done; e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t        e;
        logic [7:0]  led;
        logic        done;
        logic [31:0] cnt;
        if (sb_q.size() == 0) begin
            n_asserts++;
            n_fail++;
            $error("FAIL sb_underflow observed empty queue expected an entry");
        end else begin
            e    = sb_q.pop_front();
            led  = e.sel_b ? led_b  : led_a;
            done = e.sel_b ? done_b : done_a;
            cnt  = e.sel_b ? cnt_b  : cnt_a;
            n_asserts++;
            assert ((led & e.mask) === (e.led & e.mask)) else begin
                n_fail++;
                $error("FAIL %s led observed %h expected %h", e.tag, led & e.mask, e.led & e.mask);
            end
            n_asserts++;
            assert (done === e.done) else begin
                n_fail++;
                $error("FAIL %s done observed %b expected %b", e.tag, done, e.done);
            end
            n_asserts++;
            assert (cnt === e.cnt) else begin
                n_fail++;
                $error("FAIL %s cnt observed %0d expected %0d", e.tag, cnt, e.cnt);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_if.instr_valid = 1'b0; a_if.illegal_insn = 1'b0; a_if.exit_valid = 1'b0;
        b_if.instr_valid = 1'b0; b_if.illegal_insn = 1'b0; b_if.exit_valid = 1'b0;

        // Reset values
        step(3);
        push("rst_a", 1'b0, 8'hFF, 8'h02, 1'b0, 32'd0);
        push("rst_b", 1'b1, 8'hFF, 8'h02, 1'b0, 32'd0);
        check_pop();
        check_pop();

        // Release: cycle 0. Illegal held during the mask window must be ignored.
        rst_n = 1'b1;
        a_if.instr_valid  = 1'b1;
        a_if.illegal_insn = 1'b1;
        for (int n = 0; n <= 16; n++) begin
            push($sformatf("hb_c%0d", n), 1'b0, 8'h01, {7'd0, ((n % 16) >= 8)}, 1'b0, 32'(n));
            if (n == 3) push("mask_on_c3", 1'b0, 8'h06, 8'h06, 1'b0, 32'd3);
            if (n == 7) push("mask_off_c7", 1'b0, 8'h06, 8'h02, 1'b0, 32'd7);
        end
        for (int n = 0; n <= 16; n++) begin
            if (n == 6) begin
                a_if.instr_valid  = 1'b0;
                a_if.illegal_insn = 1'b0;
            end
            check_pop();
            if (n == 3 || n == 7) check_pop();
            if (n < 16) step(1);
        end

        // Timeout instance: TIMEOUT_CYCLES=50
        push("to_c49", 1'b1, 8'hFF, 8'h02, 1'b0, 32'd49);
        push("to_c50", 1'b1, 8'hFF, 8'h02, 1'b0, 32'd50);
        push("to_c51", 1'b1, 8'hFF, 8'h90, 1'b1, 32'd50);
        step(33);
        check_pop();
        step(1);
        check_pop();
        step(1);
        check_pop();

        // Valid exit at RUN cycle 100
        step(49);
        push("run_c100", 1'b0, 8'hFF, 8'h02, 1'b0, 32'd100);
        check_pop();
        a_if.exit_valid = 1'b1;
        push("exit_c101", 1'b0, 8'hFF, 8'h02, 1'b0, 32'd101);
        push("exit_c102", 1'b0, 8'hFF, 8'hC0, 1'b1, 32'd101);
        step(1);
        a_if.exit_valid = 1'b0;
        check_pop();
        step(1);
        check_pop();

        // Sticky: 1000 cycles with stray events
        push("sticky_a", 1'b0, 8'hFF, 8'hC0, 1'b1, 32'd101);
        push("sticky_b", 1'b1, 8'hFF, 8'h90, 1'b1, 32'd50);
        for (int i = 0; i < 1000; i++) begin
            a_if.instr_valid  = ((i % 97) == 5);
            a_if.illegal_insn = ((i % 97) == 5);
            a_if.exit_valid   = ((i % 89) == 3);
            b_if.exit_valid   = ((i % 89) == 3);
            step(1);
        end
        a_if.instr_valid = 1'b0; a_if.illegal_insn = 1'b0;
        a_if.exit_valid  = 1'b0; b_if.exit_valid   = 1'b0;
        check_pop();
        check_pop();

        // Reset, then illegal and exit together at cycle 6 (first unmasked cycle)
        rst_n = 1'b0;
        push("rst2_a", 1'b0, 8'hFF, 8'h02, 1'b0, 32'd0);
        #1;
        check_pop();
        step(1);
        rst_n = 1'b1;
        step(6);
        a_if.instr_valid  = 1'b1;
        a_if.illegal_insn = 1'b1;
        a_if.exit_valid   = 1'b1;
        push("ill_c7", 1'b0, 8'hFF, 8'h02, 1'b0, 32'd7);
        push("ill_c8", 1'b0, 8'hFF, 8'hA0, 1'b1, 32'd7);
        step(1);
        a_if.instr_valid = 1'b0; a_if.illegal_insn = 1'b0; a_if.exit_valid = 1'b0;
        check_pop();
        step(1);
        check_pop();

        // Asynchronous reset pulse mid-cycle from EXIT_ILLEGAL
        #3;
        rst_n = 1'b0;
        push("async_rst", 1'b0, 8'hFF, 8'h02, 1'b0, 32'd0);
        #1;
        check_pop();
        #1;
        rst_n = 1'b1;
        push("post_rst_c1", 1'b0, 8'hFF, 8'h06, 1'b0, 32'd1);
        step(1);
        check_pop();

        // No timeout when TIMEOUT_CYCLES=0; then a valid exit still works
        push("no_to_a", 1'b0, 8'h82, 8'h02, 1'b0, 32'd20000);
        push("to_again_b", 1'b1, 8'hFF, 8'h90, 1'b1, 32'd50);
        step(19999);
        check_pop();
        check_pop();
        a_if.exit_valid = 1'b1;
        push("exit2_c20001", 1'b0, 8'hFF, 8'h02, 1'b0, 32'd20001);
        push("exit2_c20002", 1'b0, 8'hFF, 8'hC0, 1'b1, 32'd20001);
        step(1);
        a_if.exit_valid = 1'b0;
        check_pop();
        step(1);
        check_pop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
